// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: turns a valid/ready/last byte stream into a GMII frame.
// Adds the preamble and SFD, zero-pads short frames, appends the CRC32 FCS and
// enforces the inter-frame gap. Oversize and underrun abort the frame on air
// with tx_er. All GMII-side outputs are registered.
module gmii_tx_framer #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_PAYLOAD    = 60,
  parameter int MAX_PAYLOAD    = 1514,
  parameter int IFG_BYTES      = 12,
  parameter int ENABLE_FCS     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        busy,
  output logic [15:0] frames_sent,
  output logic        underrun,
  output logic        oversize
);

  localparam int CNT_W = ($clog2(MAX_PAYLOAD + 2) > 11) ? $clog2(MAX_PAYLOAD + 2) : 11;
  localparam int PRE_W = $clog2(PREAMBLE_BYTES + 1);
  localparam int IFG_W = $clog2(IFG_BYTES + 1);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PAYLOAD);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PAYLOAD);
  localparam logic [PRE_W-1:0] PRE_C = PRE_W'(PREAMBLE_BYTES);
  localparam logic [IFG_W-1:0] IFG_C = IFG_W'(IFG_BYTES);

  // Each state decides what goes on the wire at the next clock edge.
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG, S_DRAIN
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt, w_count_inc;
  logic [PRE_W-1:0]  r_pre, w_pre_nxt, w_pre_inc;
  logic [IFG_W-1:0]  r_ifg, w_ifg_nxt, w_ifg_inc;
  logic [1:0]        r_fcs_idx, w_fcs_nxt;
  logic [31:0]       r_crc, w_crc_nxt;
  logic [15:0]       r_frames, w_frames_nxt;
  logic [7:0]        r_txd, w_txd;
  logic              r_tx_en, w_tx_en;
  logic              r_tx_er, w_tx_er;
  logic              r_busy, w_busy;
  logic              r_underrun, w_underrun;
  logic              r_oversize, w_oversize;
  logic              w_payload_done;

  // Reflected CRC32 (poly 0xEDB88320) advanced by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // FCS is the inverted CRC, least significant byte transmitted first.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = ~crc[7:0];
      2'd1:    b = ~crc[15:8];
      2'd2:    b = ~crc[23:16];
      default: b = ~crc[31:24];
    endcase
    return b;
  endfunction

  assign w_count_inc = r_count + 1'b1;
  assign w_pre_inc   = r_pre + 1'b1;
  assign w_ifg_inc   = r_ifg + 1'b1;

  // Only DATA and DRAIN take bytes from the stream.
  assign s_ready = (r_state == S_DATA) || (r_state == S_DRAIN);

  // Next-state and next-output decode for the framer FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_pre_nxt      = r_pre;
    w_ifg_nxt      = r_ifg;
    w_fcs_nxt      = r_fcs_idx;
    w_crc_nxt      = r_crc;
    w_frames_nxt   = r_frames;
    w_txd          = 8'h00;
    w_tx_en        = 1'b0;
    w_tx_er        = 1'b0;
    w_underrun     = 1'b0;
    w_oversize     = 1'b0;
    w_busy         = (r_state != S_IDLE);
    w_payload_done = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (s_valid) begin
          w_txd       = 8'h55;
          w_tx_en     = 1'b1;
          w_busy      = 1'b1;
          w_pre_nxt   = PRE_W'(1);
          w_state_nxt = (PREAMBLE_BYTES == 1) ? S_SFD : S_PRE;
        end
      end
      S_PRE: begin
        w_txd     = 8'h55;
        w_tx_en   = 1'b1;
        w_pre_nxt = w_pre_inc;
        if (w_pre_inc == PRE_C) w_state_nxt = S_SFD;
      end
      S_SFD: begin
        w_txd       = 8'hD5;
        w_tx_en     = 1'b1;
        w_crc_nxt   = 32'hFFFFFFFF;
        w_count_nxt = '0;
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_tx_en = 1'b1;
        if (!s_valid) begin
          w_tx_er     = 1'b1;
          w_underrun  = 1'b1;
          w_state_nxt = S_DRAIN;
        end else if (r_count == MAX_C) begin
          // The excess byte is consumed but never transmitted.
          w_tx_er     = 1'b1;
          w_oversize  = 1'b1;
          w_ifg_nxt   = '0;
          w_state_nxt = s_last ? S_IFG : S_DRAIN;
        end else begin
          w_txd       = s_data;
          w_count_nxt = w_count_inc;
          w_crc_nxt   = crc32_byte(r_crc, s_data);
          if (s_last) begin
            if (w_count_inc < MIN_C) w_state_nxt = S_PAD;
            else                     w_payload_done = 1'b1;
          end
        end
      end
      S_PAD: begin
        w_tx_en     = 1'b1;
        w_count_nxt = w_count_inc;
        w_crc_nxt   = crc32_byte(r_crc, 8'h00);
        if (w_count_inc >= MIN_C) w_payload_done = 1'b1;
      end
      S_FCS: begin
        w_txd     = fcs_byte(r_crc, r_fcs_idx);
        w_tx_en   = 1'b1;
        w_fcs_nxt = r_fcs_idx + 2'd1;
        if (r_fcs_idx == 2'd3) begin
          w_frames_nxt = r_frames + 16'd1;
          w_ifg_nxt    = '0;
          w_state_nxt  = S_IFG;
        end
      end
      S_IFG: begin
        w_ifg_nxt = w_ifg_inc;
        if (w_ifg_inc == IFG_C) w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (s_valid && s_last) begin
          w_ifg_nxt   = '0;
          w_state_nxt = S_IFG;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Last data/pad byte chosen: either append the FCS or close the frame here.
    if (w_payload_done) begin
      if (ENABLE_FCS != 0) begin
        w_fcs_nxt   = 2'd0;
        w_state_nxt = S_FCS;
      end else begin
        w_frames_nxt = r_frames + 16'd1;
        w_ifg_nxt    = '0;
        w_state_nxt  = S_IFG;
      end
    end
  end

  // State, counters, CRC and registered GMII outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_pre      <= '0;
      r_ifg      <= '0;
      r_fcs_idx  <= 2'd0;
      r_crc      <= 32'hFFFFFFFF;
      r_frames   <= 16'd0;
      r_txd      <= 8'h00;
      r_tx_en    <= 1'b0;
      r_tx_er    <= 1'b0;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
      r_oversize <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_pre      <= w_pre_nxt;
      r_ifg      <= w_ifg_nxt;
      r_fcs_idx  <= w_fcs_nxt;
      r_crc      <= w_crc_nxt;
      r_frames   <= w_frames_nxt;
      r_txd      <= w_txd;
      r_tx_en    <= w_tx_en;
      r_tx_er    <= w_tx_er;
      r_busy     <= w_busy;
      r_underrun <= w_underrun;
      r_oversize <= w_oversize;
    end
  end

  assign gmii_txd    = r_txd;
  assign gmii_tx_en  = r_tx_en;
  assign gmii_tx_er  = r_tx_er;
  assign busy        = r_busy;
  assign frames_sent = r_frames;
  assign underrun    = r_underrun;
  assign oversize    = r_oversize;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: two instances (defaults, and MIN_PAYLOAD=0 /
// MAX_PAYLOAD=64) share one stimulus port set selected by 'sel'. Expected
// frames come from a frame-level model (preamble, payload, pad, bit-serial CRC).
module tb_gmii_tx_framer;

  typedef logic [7:0] bq_t [$];
  typedef struct packed {
    logic       en;
    logic       er;
    logic [7:0] d;
    logic       bsy;
    logic       un;
    logic       ov;
  } smp_t;

  logic        clock   = 1'b0;
  logic        reset   = 1'b1;
  logic [7:0]  s_data  = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last  = 1'b0;
  logic        sel     = 1'b0;
  logic        va, vb;

  logic        a_ready, a_en, a_er, a_busy, a_un, a_ov;
  logic [7:0]  a_txd;
  logic [15:0] a_frames;
  logic        b_ready, b_en, b_er, b_busy, b_un, b_ov;
  logic [7:0]  b_txd;
  logic [15:0] b_frames;

  logic        ready, en, er, bsy, un, ov;
  logic [7:0]  txd;
  logic [15:0] frames;

  int checks = 0;
  int errors = 0;
  int exp_a  = 0;
  int exp_b  = 0;

  smp_t cap[$];
  logic rec = 1'b0;

  always #4 clock = ~clock;

  assign va     = s_valid & ~sel;
  assign vb     = s_valid & sel;
  assign ready  = sel ? b_ready  : a_ready;
  assign en     = sel ? b_en     : a_en;
  assign er     = sel ? b_er     : a_er;
  assign bsy    = sel ? b_busy   : a_busy;
  assign un     = sel ? b_un     : a_un;
  assign ov     = sel ? b_ov     : a_ov;
  assign txd    = sel ? b_txd    : a_txd;
  assign frames = sel ? b_frames : a_frames;

  gmii_tx_framer u_a (
    .clock(clock), .reset(reset), .s_data(s_data), .s_valid(va), .s_last(s_last),
    .s_ready(a_ready), .gmii_txd(a_txd), .gmii_tx_en(a_en), .gmii_tx_er(a_er),
    .busy(a_busy), .frames_sent(a_frames), .underrun(a_un), .oversize(a_ov)
  );

  gmii_tx_framer #(.MIN_PAYLOAD(0), .MAX_PAYLOAD(64)) u_b (
    .clock(clock), .reset(reset), .s_data(s_data), .s_valid(vb), .s_last(s_last),
    .s_ready(b_ready), .gmii_txd(b_txd), .gmii_tx_en(b_en), .gmii_tx_er(b_er),
    .busy(b_busy), .frames_sent(b_frames), .underrun(b_un), .oversize(b_ov)
  );

  always @(negedge clock) if (rec) cap.push_back({en, er, txd, bsy, un, ov});

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] crc_model(input bq_t q, input int first);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    for (int i = first; i < q.size(); i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return c;
  endfunction

  function automatic bq_t build_frame(input bq_t p, input int minp);
    bq_t f;
    logic [31:0] fcs;
    int n;
    for (int i = 0; i < 7; i++) f.push_back(8'h55);
    f.push_back(8'hD5);
    foreach (p[i]) f.push_back(p[i]);
    n = p.size();
    while (n < minp) begin f.push_back(8'h00); n++; end
    fcs = ~crc_model(f, 8);
    f.push_back(fcs[7:0]);   f.push_back(fcs[15:8]);
    f.push_back(fcs[23:16]); f.push_back(fcs[31:24]);
    return f;
  endfunction

  function automatic bq_t rand_payload(input int len);
    bq_t p;
    for (int i = 0; i < len; i++) p.push_back(8'($urandom_range(0, 255)));
    return p;
  endfunction

  function automatic bq_t en_bytes();
    bq_t q;
    foreach (cap[i]) if (cap[i].en) q.push_back(cap[i].d);
    return q;
  endfunction

  function automatic int first_diff(input bq_t got, input bq_t want);
    int n;
    n = (got.size() < want.size()) ? got.size() : want.size();
    for (int i = 0; i < n; i++) if (got[i] !== want[i]) return i;
    return (got.size() == want.size()) ? -1 : n;
  endfunction

  function automatic int count_en();
    int n = 0;
    foreach (cap[i]) if (cap[i].en) n++;
    return n;
  endfunction

  function automatic int count_er();
    int n = 0;
    foreach (cap[i]) if (cap[i].er) n++;
    return n;
  endfunction

  function automatic int count_un();
    int n = 0;
    foreach (cap[i]) if (cap[i].un) n++;
    return n;
  endfunction

  function automatic int count_ov();
    int n = 0;
    foreach (cap[i]) if (cap[i].ov) n++;
    return n;
  endfunction

  // ---------------- stimulus ----------------
  task automatic send(input bq_t p, input int drop_at, input bit keep_valid);
    int i = 0;
    int guard = 0;
    bit hs;
    bit dropped = 1'b0;
    while (i < p.size() && guard < 5000) begin
      if (i == drop_at && !dropped) begin
        s_valid = 1'b0; s_last = 1'b0;
        @(posedge clock); #1;
        dropped = 1'b1;
      end else begin
        s_valid = 1'b1; s_data = p[i]; s_last = (i == p.size() - 1);
        @(negedge clock); hs = ready;
        @(posedge clock); #1;
        if (hs) i++;
      end
      guard++;
    end
    if (guard >= 5000) begin
      checks++; errors++;
      $display("FAIL send_timeout accepted %0d of %0d bytes", i, p.size());
    end
    if (!keep_valid) begin s_valid = 1'b0; s_last = 1'b0; end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clock); n++; end while (bsy !== 1'b0 && n < 4000);
    if (bsy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL %s_timeout busy still %b after %0d cycles", name, bsy, n);
    end
  endtask

  task automatic run_frame(input bq_t p, input int drop_at, input string name);
    cap.delete();
    rec = 1'b1;
    send(p, drop_at, 1'b0);
    wait_idle(name);
    rec = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel = 1'b0; reset = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (a_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en got %b want 0", a_en); end
    checks++; if (a_txd !== 8'h00) begin errors++; $display("FAIL reset_txd got %h want 00", a_txd); end
    checks++; if (a_er !== 1'b0) begin errors++; $display("FAIL reset_tx_er got %b want 0", a_er); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", a_busy); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", a_ready); end
    checks++; if (a_frames !== 16'd0) begin errors++; $display("FAIL reset_frames got %0d want 0", a_frames); end
    checks++;
    if ({a_un, a_ov, b_un, b_ov} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses got %b want 0000", {a_un, a_ov, b_un, b_ov});
    end
    checks++;
    if ({b_en, b_busy, b_frames} !== 18'd0) begin
      errors++; $display("FAIL reset_b_outputs got %h want 0", {b_en, b_busy, b_frames});
    end
    s_valid = 1'b0;
    @(posedge clock); #1; reset = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({a_en, a_busy} !== 2'b00) begin
      errors++; $display("FAIL idle_quiet got en/busy %b want 00", {a_en, a_busy});
    end
  endtask

  task automatic test_crc_vector();
    bq_t p, got, want;
    int bad;
    sel = 1'b1;
    for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
    for (int i = 0; i < 7; i++) want.push_back(8'h55);
    want.push_back(8'hD5);
    foreach (p[i]) want.push_back(p[i]);
    want.push_back(8'h26); want.push_back(8'h39); want.push_back(8'hF4); want.push_back(8'hCB);
    run_frame(p, -1, "crc_vector");
    got = en_bytes();
    bad = first_diff(got, want);
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL crc_vector got_len %0d want_len %0d first_diff %0d", got.size(), want.size(), bad);
    end
    exp_b++;
    checks++; if (b_frames !== 16'(exp_b)) begin errors++; $display("FAIL crc_vector_frames got %0d want %0d", b_frames, exp_b); end
    checks++; if (count_er() != 0) begin errors++; $display("FAIL crc_vector_tx_er got %0d want 0", count_er()); end
  endtask

  task automatic test_pad_min();
    bq_t p, got, want;
    int bad;
    sel = 1'b0;
    p = rand_payload(14);
    want = build_frame(p, 60);
    run_frame(p, -1, "pad_min");
    got = en_bytes();
    checks++; if (got.size() != 72) begin errors++; $display("FAIL pad_en_cycles got %0d want 72", got.size()); end
    bad = first_diff(got, want);
    checks++; if (bad >= 0) begin errors++; $display("FAIL pad_bytes first_diff %0d got_len %0d", bad, got.size()); end
    exp_a++;
    checks++; if (a_frames !== 16'(exp_a)) begin errors++; $display("FAIL pad_frames got %0d want %0d", a_frames, exp_a); end
  endtask

  task automatic test_random_frames();
    bq_t p, got, want;
    int len, bad;
    for (int k = 0; k < 8; k++) begin
      sel = (k >= 5);
      case (k)
        0: len = 1;
        1: len = 59;
        2: len = 60;
        3: len = 61;
        4: len = $urandom_range(62, 200);
        5: len = 64;
        6: len = 1;
        default: len = $urandom_range(2, 63);
      endcase
      p = rand_payload(len);
      want = build_frame(p, sel ? 0 : 60);
      run_frame(p, -1, "rand_frame");
      got = en_bytes();
      bad = first_diff(got, want);
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL rand_frame%0d len %0d got_len %0d want_len %0d first_diff %0d",
                 k, len, got.size(), want.size(), bad);
      end
      if (sel) exp_b++; else exp_a++;
      checks++;
      if (frames !== 16'(sel ? exp_b : exp_a)) begin
        errors++; $display("FAIL rand_frames%0d got %0d want %0d", k, frames, sel ? exp_b : exp_a);
      end
      checks++; if (count_er() != 0) begin errors++; $display("FAIL rand_tx_er%0d got %0d want 0", k, count_er()); end
    end
  endtask

  task automatic test_back_to_back();
    bq_t p1, p2, got, want, w2;
    int runs = 0, end1 = -1, start2 = -1, bad;
    sel = 1'b0;
    p1 = rand_payload($urandom_range(20, 80));
    p2 = rand_payload($urandom_range(1, 40));
    want = build_frame(p1, 60);
    w2 = build_frame(p2, 60);
    foreach (w2[i]) want.push_back(w2[i]);
    cap.delete();
    rec = 1'b1;
    send(p1, -1, 1'b1);
    send(p2, -1, 1'b0);
    wait_idle("b2b");
    rec = 1'b0;
    foreach (cap[i]) begin
      if (cap[i].en && (i == 0 || !cap[i-1].en)) begin
        runs++;
        if (runs == 2) start2 = i;
      end
      if (cap[i].en && runs == 1) end1 = i;
    end
    checks++; if (runs != 2) begin errors++; $display("FAIL b2b_runs got %0d want 2", runs); end
    checks++;
    if (start2 - end1 - 1 != 12) begin
      errors++; $display("FAIL b2b_gap got %0d want 12", start2 - end1 - 1);
    end
    got = en_bytes();
    bad = first_diff(got, want);
    checks++; if (bad >= 0) begin errors++; $display("FAIL b2b_bytes first_diff %0d got_len %0d want_len %0d", bad, got.size(), want.size()); end
    exp_a += 2;
    checks++; if (a_frames !== 16'(exp_a)) begin errors++; $display("FAIL b2b_frames got %0d want %0d", a_frames, exp_a); end
  endtask

  task automatic test_underrun();
    bq_t p, got, want, full;
    int k = -1, after = 0, en_after = 0, bad;
    sel = 1'b0;
    p = rand_payload(30);
    full = build_frame(p, 60);
    for (int i = 0; i < 28; i++) want.push_back(full[i]);
    want.push_back(8'h00);
    run_frame(p, 20, "underrun");
    got = en_bytes();
    bad = first_diff(got, want);
    checks++; if (bad >= 0) begin errors++; $display("FAIL underrun_bytes first_diff %0d got_len %0d want_len 29", bad, got.size()); end
    foreach (cap[i]) if (cap[i].er && k < 0) k = i;
    checks++; if (count_er() != 1) begin errors++; $display("FAIL underrun_er_cycles got %0d want 1", count_er()); end
    checks++; if (count_un() != 1) begin errors++; $display("FAIL underrun_pulses got %0d want 1", count_un()); end
    checks++;
    if (k < 0 || cap[k].un !== 1'b1 || cap[k].en !== 1'b1) begin
      errors++; $display("FAIL underrun_align er_index %0d un/en not both 1", k);
    end
    for (int i = k + 1; k >= 0 && i < cap.size() && cap[i].bsy; i++) begin
      after++;
      if (cap[i].en) en_after++;
    end
    checks++; if (after != 22) begin errors++; $display("FAIL underrun_drain_ifg got %0d busy cycles want 22", after); end
    checks++; if (en_after != 0) begin errors++; $display("FAIL underrun_en_after got %0d want 0", en_after); end
    checks++; if (count_ov() != 0) begin errors++; $display("FAIL underrun_oversize got %0d want 0", count_ov()); end
    checks++; if (a_frames !== 16'(exp_a)) begin errors++; $display("FAIL underrun_frames got %0d want %0d", a_frames, exp_a); end
  endtask

  task automatic test_oversize();
    bq_t p, got, want, full;
    int k = -1, after = 0, bad;
    sel = 1'b1;
    p = rand_payload(70);
    full = build_frame(p, 0);
    for (int i = 0; i < 72; i++) want.push_back(full[i]);
    want.push_back(8'h00);
    run_frame(p, -1, "oversize");
    got = en_bytes();
    bad = first_diff(got, want);
    checks++; if (bad >= 0) begin errors++; $display("FAIL oversize_bytes first_diff %0d got_len %0d want_len 73", bad, got.size()); end
    foreach (cap[i]) if (cap[i].er && k < 0) k = i;
    checks++; if (count_ov() != 1) begin errors++; $display("FAIL oversize_pulses got %0d want 1", count_ov()); end
    checks++;
    if (k < 0 || cap[k].ov !== 1'b1) begin
      errors++; $display("FAIL oversize_align er_index %0d pulse not aligned", k);
    end
    for (int i = k + 1; k >= 0 && i < cap.size() && cap[i].bsy; i++) after++;
    checks++; if (after != 17) begin errors++; $display("FAIL oversize_drain_ifg got %0d busy cycles want 17", after); end
    checks++; if (count_un() != 0) begin errors++; $display("FAIL oversize_underrun got %0d want 0", count_un()); end
    checks++; if (b_frames !== 16'(exp_b)) begin errors++; $display("FAIL oversize_frames got %0d want %0d", b_frames, exp_b); end
  endtask

  task automatic test_reset_during_fcs();
    bq_t p, got, want;
    int n = 0, bad;
    sel = 1'b0;
    p = rand_payload(10);
    want = build_frame(p, 60);
    cap.delete();
    rec = 1'b1;
    send(p, -1, 1'b0);
    while (count_en() < 69 && n < 500) begin @(negedge clock); #1; n++; end
    checks++;
    if (a_txd !== want[68]) begin
      errors++; $display("FAIL rst_fcs_first_byte got %h want %h", a_txd, want[68]);
    end
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rec = 1'b0;
    checks++;
    if ({a_en, a_busy, a_ready, a_er} !== 4'b0000) begin
      errors++; $display("FAIL rst_fcs_outputs got en/busy/ready/er %b want 0000", {a_en, a_busy, a_ready, a_er});
    end
    checks++; if (a_frames !== 16'd0) begin errors++; $display("FAIL rst_fcs_frames got %0d want 0", a_frames); end
    @(posedge clock); #1; reset = 1'b0;
    exp_a = 0; exp_b = 0;
    p = rand_payload($urandom_range(1, 80));
    want = build_frame(p, 60);
    run_frame(p, -1, "post_reset");
    got = en_bytes();
    bad = first_diff(got, want);
    checks++; if (bad >= 0) begin errors++; $display("FAIL post_reset_bytes first_diff %0d got_len %0d want_len %0d", bad, got.size(), want.size()); end
    exp_a++;
    checks++; if (a_frames !== 16'(exp_a)) begin errors++; $display("FAIL post_reset_frames got %0d want %0d", a_frames, exp_a); end
  endtask

  initial begin
    test_reset();
    test_crc_vector();
    test_pad_min();
    test_random_frames();
    test_back_to_back();
    test_underrun();
    test_oversize();
    test_reset_during_fcs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
